// File: rtl/lsu_mmio.sv
`default_nettype none
// ============================================================================
// lsu_mmio : byte/half/word load-store unit, data RAM + MMIO window.
//            Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.  Rev 1.0
// ============================================================================
module lsu_mmio #(
    parameter int DMEM_WORDS = 512,
    parameter int NUM_HEX    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [11:0]             addr_i,
    input  logic [1:0]              size_i,
    input  logic                    unsigned_i,
    input  logic [31:0]             st_data_i,
    input  logic [31:0]             io_sw_i,
    output logic [31:0]             ld_data_o,
    output logic                    ld_valid_o,
    output logic                    misalign_o,
    output logic [32*NUM_HEX-1:0]   io_hex_o,
    output logic [31:0]             io_ledr_o,
    output logic [31:0]             io_ledg_o,
    output logic [31:0]             io_lcd_o
);
    localparam int         c_AW        = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [9:0] c_WIDX_HEX0 = 10'h200;
    localparam logic [9:0] c_WIDX_LEDR = 10'h220;
    localparam logic [9:0] c_WIDX_LEDG = 10'h224;
    localparam logic [9:0] c_WIDX_LCD  = 10'h228;
    localparam logic [9:0] c_WIDX_SW   = 10'h240;

    logic [31:0] mem [DMEM_WORDS];
    logic [31:0] hex_q [NUM_HEX];
    logic [31:0] ledr_q, ledg_q, lcd_q, sw_q1, sw_q2;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;

    logic [9:0]  widx;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata, rd_word, rd_shift;
    logic        ram_hit, hex_hit, reject, acc_ok, wr_en;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  en);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = en[b] ? data[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

    assign widx    = addr_i[11:2];
    assign ram_hit = widx < 10'(DMEM_WORDS);
    assign hex_hit = (widx[9:5] == 5'b10000) && (widx[1:0] == 2'b00) &&
                     ({1'b0, widx[4:2]} < 4'(NUM_HEX));

    // Lane offset is always size-aligned; under the trap build misaligned
    // requests never reach here, so this is also the forced-alignment rule.
    always_comb begin
        off   = 2'b00;
        be    = 4'b1111;
        wdata = st_data_i;
        case (size_i)
            2'b00: begin
                off   = addr_i[1:0];
                be    = 4'b0001 << addr_i[1:0];
                wdata = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                off   = {addr_i[1], 1'b0};
                be    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign reject = req_i && (((size_i == 2'b01) && addr_i[0]) ||
                              (size_i[1] && (addr_i[1:0] != 2'b00)));
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) misalign_q <= 1'b0;
        else         misalign_q <= reject;
    end
    assign misalign_o = misalign_q;
`else
    assign reject     = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign acc_ok     = req_i && !reject;
    assign wr_en      = acc_ok && we_i;
    assign ld_valid_d = acc_ok && !we_i;

    always_ff @(posedge clk_i) begin
        if (wr_en && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx[c_AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= '0;
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            sw_q1  <= '0;
            sw_q2  <= '0;
        end else begin
            sw_q1 <= io_sw_i;
            sw_q2 <= sw_q1;
            if (wr_en) begin
                for (int i = 0; i < NUM_HEX; i++) begin
                    if (widx == c_WIDX_HEX0 + 10'(4*i)) hex_q[i] <= merge_lanes(hex_q[i], wdata, be);
                end
                if (widx == c_WIDX_LEDR) ledr_q <= merge_lanes(ledr_q, wdata, be);
                if (widx == c_WIDX_LEDG) ledg_q <= merge_lanes(ledg_q, wdata, be);
                if (widx == c_WIDX_LCD)  lcd_q  <= merge_lanes(lcd_q,  wdata, be);
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (ram_hit)                  rd_word = mem[widx[c_AW-1:0]];
        else if (hex_hit)             rd_word = hex_q[widx[4:2]];
        else if (widx == c_WIDX_LEDR) rd_word = ledr_q;
        else if (widx == c_WIDX_LEDG) rd_word = ledg_q;
        else if (widx == c_WIDX_LCD)  rd_word = lcd_q;
        else if (widx == c_WIDX_SW)   rd_word = sw_q2;
    end

    always_comb begin
        rd_shift  = rd_word >> {off, 3'b000};
        ld_data_d = rd_shift;
        case (size_i)
            2'b00:   ld_data_d = unsigned_i ? {24'h0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_data_d = unsigned_i ? {16'h0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data_d = rd_shift;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
        end else begin
            ld_valid_q <= ld_valid_d;
            if (ld_valid_d) ld_data_q <= ld_data_d;
        end
    end

    assign ld_valid_o = ld_valid_q;
    assign ld_data_o  = ld_data_q;
    assign io_ledr_o  = ledr_q;
    assign io_ledg_o  = ledg_q;
    assign io_lcd_o   = lcd_q;

    generate
        for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex_out
            assign io_hex_o[32*gi +: 32] = hex_q[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lsu_mmio.sv
`default_nettype none
// ============================================================================
// tb_lsu_mmio : self-checking bench for lsu_mmio (byte-addressed reference
//               model, directed vector table, corner sequences).  Rev 1.0
// ============================================================================
module tb_lsu_mmio;
    localparam int DMEM_WORDS = 512;
    localparam int NUM_HEX    = 8;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  req_i = 1'b0;
    logic                  we_i = 1'b0;
    logic [11:0]           addr_i = '0;
    logic [1:0]            size_i = '0;
    logic                  unsigned_i = 1'b0;
    logic [31:0]           st_data_i = '0;
    logic [31:0]           io_sw_i = '0;
    logic [31:0]           ld_data_o;
    logic                  ld_valid_o;
    logic                  misalign_o;
    logic [32*NUM_HEX-1:0] io_hex_o;
    logic [31:0]           io_ledr_o, io_ledg_o, io_lcd_o;

    lsu_mmio #(.DMEM_WORDS(DMEM_WORDS), .NUM_HEX(NUM_HEX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .st_data_i(st_data_i), .io_sw_i(io_sw_i), .ld_data_o(ld_data_o),
        .ld_valid_o(ld_valid_o), .misalign_o(misalign_o), .io_hex_o(io_hex_o),
        .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o), .io_lcd_o(io_lcd_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference state: one byte per address of the 4 KiB window.
    logic [7:0]  mb [4096];
    logic [31:0] sw_h0, sw_h1, sw_h2;
    logic [31:0] exp_data;
    logic        exp_valid, exp_mis;

    typedef struct {
        string       name;
        bit          we;
        int          addr;
        int          size;
        bit          uns;
        logic [31:0] data;
        bit          ev;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic bit is_ram(input int a);
        return a < 4*DMEM_WORDS;
    endfunction

    function automatic bit is_reg(input int a);
        return (a >= 'h800) && (a < 'h8B0) && ((a & 'hC) == 0);
    endfunction

    function automatic logic [7:0] rd_byte(input int a);
        if (is_ram(a) || is_reg(a)) return mb[a];
        if (a >= 'h900 && a < 'h904) return sw_h2[8*(a-'h900) +: 8];
        return 8'h00;
    endfunction

    function automatic logic [31:0] word_at(input int a);
        return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endfunction

    task automatic reset_model();
        for (int a = 'h800; a < 'h8B0; a++) mb[a] = 8'h00;
        sw_h0 = '0; sw_h1 = '0; sw_h2 = '0;
        exp_data = '0; exp_valid = 1'b0; exp_mis = 1'b0;
    endtask

    // Drive one request cycle, predict its outcome, advance past the edge.
    task automatic step(input bit req, input bit we, input int addr, input int size,
                        input bit uns, input logic [31:0] data);
        int n, ea;
        bit mis;
        logic [31:0] v;
        req_i = req; we_i = we; addr_i = 12'(addr); size_i = 2'(size);
        unsigned_i = uns; st_data_i = data;
        sw_h2 = sw_h1; sw_h1 = sw_h0; sw_h0 = io_sw_i;
        n   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        mis = (addr % n) != 0;
        ea  = addr - (addr % n);
        exp_valid = 1'b0; exp_mis = 1'b0;
        if (req) begin
            if (mis && TRAP) begin
                exp_mis = 1'b1;
            end else if (we) begin
                for (int k = 0; k < n; k++)
                    if (is_ram(ea+k) || is_reg(ea+k)) mb[ea+k] = data[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < n; k++) v = v | (32'(rd_byte(ea+k)) << (8*k));
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                exp_valid = 1'b1;
                exp_data  = v;
            end
        end
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(ld_valid_o), 32'(exp_valid));
        chk({tag, ".misalign"}, 32'(misalign_o), 32'(exp_mis));
        chk({tag, ".ld_data"}, ld_data_o, exp_data);
        chk({tag, ".ledr"}, io_ledr_o, word_at('h880));
        chk({tag, ".ledg"}, io_ledg_o, word_at('h890));
        chk({tag, ".lcd"},  io_lcd_o,  word_at('h8A0));
        for (int i = 0; i < NUM_HEX; i++)
            chk($sformatf("%s.hex%0d", tag, i), io_hex_o[32*i +: 32], word_at('h800 + 16*i));
    endtask

    initial begin
        tbl[0] = '{"rst_ledr_ld",  1'b0, 'h880, 2, 1'b0, 32'h0,        1'b1, 32'h0000_0000};
        tbl[1] = '{"st_w_010",     1'b1, 'h010, 2, 1'b0, 32'h11223344, 1'b0, 32'h0};
        tbl[2] = '{"st_b_013",     1'b1, 'h013, 0, 1'b0, 32'h0000_00AA, 1'b0, 32'h0};
        tbl[3] = '{"ld_w_010",     1'b0, 'h010, 2, 1'b0, 32'h0,        1'b1, 32'hAA22_3344};
        tbl[4] = '{"ld_bs_013",    1'b0, 'h013, 0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFAA};
        tbl[5] = '{"ld_bu_013",    1'b0, 'h013, 0, 1'b1, 32'h0,        1'b1, 32'h0000_00AA};
        tbl[6] = '{"st_h_802",     1'b1, 'h802, 1, 1'b0, 32'h0000_8001, 1'b0, 32'h0};
        tbl[7] = '{"ld_hs_802",    1'b0, 'h802, 1, 1'b0, 32'h0,        1'b1, 32'hFFFF_8001};
        tbl[8] = '{"ld_unmapped",  1'b0, 'hA00, 2, 1'b0, 32'h0,        1'b1, 32'h0000_0000};

        // Reset state
        reset_model();
        repeat (3) @(posedge clk_i);
        #1;
        check_model("reset");
        rst_ni = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].data);
            chk({tbl[i].name, ".tvalid"}, 32'(ld_valid_o), 32'(tbl[i].ev));
            if (tbl[i].ev) chk({tbl[i].name, ".tdata"}, ld_data_o, tbl[i].ed);
            check_model(tbl[i].name);
        end
        chk("hex0_after_half", io_hex_o[31:0], 32'h8001_0000);

        // Known contents for the low RAM region used by random traffic
        for (int w = 0; w < 64; w++) begin
            step(1'b1, 1'b1, 4*w, 2, 1'b0, $urandom());
            check_model("init");
        end

        // Switch synchroniser latency and read-only switch word
        io_sw_i = 32'h0;
        repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        io_sw_i = 32'h5A5A_0003;
        step(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 'h900, 2, 1'b0, 32'h0);
        chk("sw_old", ld_data_o, 32'h0000_0000);
        check_model("sw_old");
        step(1'b1, 1'b0, 'h900, 2, 1'b0, 32'h0);
        chk("sw_new", ld_data_o, 32'h5A5A_0003);
        step(1'b1, 1'b1, 'h900, 2, 1'b0, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 'h900, 2, 1'b0, 32'h0);
        chk("sw_store_dropped", ld_data_o, 32'h5A5A_0003);
        check_model("sw_ro");

        // Misaligned store / load
        step(1'b1, 1'b1, 'h004, 2, 1'b0, 32'hCAFE_F00D);
        step(1'b1, 1'b1, 'h006, 2, 1'b0, 32'h1234_5678);
        chk("mis_st_pulse", 32'(misalign_o), 32'(TRAP));
        check_model("mis_st");
        step(1'b1, 1'b0, 'h004, 2, 1'b0, 32'h0);
        chk("mis_st_word1", ld_data_o, TRAP ? 32'hCAFE_F00D : 32'h1234_5678);
        step(1'b1, 1'b0, 'h803, 1, 1'b0, 32'h0);
        chk("mis_ld_valid", 32'(ld_valid_o), 32'(!TRAP));
        chk("mis_ld_pulse", 32'(misalign_o), 32'(TRAP));
        check_model("mis_ld");

        // Reset asserted while a load result is pending
        step(1'b1, 1'b1, 'h880, 2, 1'b0, 32'hDEAD_BEEF);
        req_i = 1'b1; we_i = 1'b0; addr_i = 12'h7FC; size_i = 2'd2;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid.valid", 32'(ld_valid_o), 32'h0);
        chk("rst_mid.data", ld_data_o, 32'h0);
        chk("rst_mid.ledr", io_ledr_o, 32'h0);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_mid.no_pulse", 32'(ld_valid_o), 32'h0);
        reset_model();
        sw_h0 = io_sw_i;
        step(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        check_model("rst_after");

        // Randomized traffic against the reference model
        for (int t = 0; t < 600; t++) begin
            int a;
            case ($urandom_range(0, 4))
                0, 1:    a = $urandom_range(0, 255);
                2:       a = 'h800 + 16*$urandom_range(0, 10) + $urandom_range(0, 3);
                3:       a = 'h900 + $urandom_range(0, 7);
                default: a = $urandom_range('h800, 'hFFF);
            endcase
            if ($urandom_range(0, 3) == 0) io_sw_i = $urandom();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, a,
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom());
            check_model($sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lsu_mmio.md
# lsu_mmio

Parametrised load/store unit for the single-cycle RISC-V core: byte/halfword/word stores with lane enables, sign/zero-extended loads with a registered one-cycle read, a configurable-depth data RAM, and a memory-mapped peripheral window of output registers plus a synchronised switch input. Sits between the ALU address/rs2 datapath and the board I/O, replacing the word-only store path.

## Interface
- `DMEM_WORDS`, default 512: number of 32-bit data RAM words, range 1..512, mapped from byte 0x000.
- `NUM_HEX`, default 8: number of seven-segment output registers, range 1..8.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  access request this cycle.
- `we_i`  in  1  1 = store, 0 = load; ignored when `req_i`=0.
- `addr_i`  in  12  byte address.
- `size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `unsigned_i`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `st_data_i`  in  32  store data, right-aligned.
- `io_sw_i`  in  32  asynchronous switch inputs.
- `ld_data_o`  out  32  extended load result.
- `ld_valid_o`  out  1  one-cycle pulse, `ld_data_o` valid.
- `misalign_o`  out  1  one-cycle pulse, access rejected (see Configuration).
- `io_hex_o`  out  32*NUM_HEX  hex registers, hex i at bits [32i+31:32i].
- `io_ledr_o`, `io_ledg_o`, `io_lcd_o`  out  32 each  LED/LCD registers.

## Operation
- Memory map (word index = addr_i[11:2]): RAM 0x000..4*DMEM_WORDS-1; hex i at 0x800+0x10*i; LEDR 0x880; LEDG 0x890; LCD 0x8A0; switches 0x900 (read-only). Peripheral registers decode on addr_i[11:2] only. All other addresses unmapped.
- Store: byte writes lane addr_i[1:0] with st_data_i[7:0]; half writes lanes {addr_i[1],0}/+1 with st_data_i[15:0]; word writes all lanes. Other lanes unchanged. Same lane rules for peripheral registers. Stores to 0x900 or unmapped addresses are dropped silently.
- Load: selects lane(s) by addr_i[1:0]/size_i, extends per `unsigned_i`. Unmapped reads return 0. Peripheral registers are readable.
- Switch path: 2-flop synchroniser `sw_q1`→`sw_q2`; 0x900 reads `sw_q2`.
- Misaligned: half with addr_i[0]=1, word with addr_i[1:0]≠00.
- One request per cycle; no backpressure.

## Timing
- Reset (async assert, sync release): all peripheral registers, `sw_q1/sw_q2`, `ld_data_o`, `ld_valid_o`, `misalign_o` = 0. RAM contents are not reset.
- Store committed at the rising edge of the request cycle; visible to a load requested the next cycle.
- Load latency 1: request at edge N → `ld_valid_o`=1 and `ld_data_o` valid after edge N+1 for one cycle; `ld_data_o` holds last value when `ld_valid_o`=0.
- Switch change reaches a 0x900 load result after 2 edges synchroniser + 1 edge load.
- Reset asserted mid-load: pending `ld_valid_o` is cleared, no pulse after release.
- `misalign_o` pulses the cycle after the offending request (aligned with where `ld_valid_o` would be); `ld_valid_o` stays 0 for a rejected load.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned stores are dropped (no lane written) and misaligned loads return no `ld_valid_o`; `misalign_o` pulses.
- Undefined: `misalign_o` tied 0; misaligned accesses are forcibly aligned (half uses addr_i[1], word ignores addr_i[1:0]) and complete normally.

## Test plan
- Reset then load 0x880 → after 1 cycle `ld_valid_o`=1, `ld_data_o`=0x00000000; all outputs 0.
- Word store 0x11223344 to 0x010, byte store 0xAA to 0x013, load word 0x010 → 0xAA223344; signed byte load 0x013 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Half store 0x8001 to 0x802 (hex0) → `io_hex_o[31:0]`=0x80010000; signed half load 0x802 → 0xFFFF8001.
- `io_sw_i`=0x5A5A0003 then load 0x900 next cycle → old value; load issued 2 cycles after change → 0x5A5A0003. Store to 0x900 → no change.
- Word store to 0x006 with macro defined → RAM word 1 unchanged, `misalign_o` pulse; without macro → word 1 overwritten, `misalign_o`=0.
- Load 0x7FC issued, `rst_ni` pulsed low before next edge → `ld_valid_o` never asserts; load to unmapped 0xA00 → 0x00000000.
